// File: rtl/mem_io_responder.sv
// Memory-bus responder: word RAM, LED register, switch port and character FIFO, with 1-cycle registered DIN.
// A write commits on every edge with W=1. The character sink is valid/ready, and a push to a full FIFO drops the byte and sets sticky overflow.
module mem_io_responder #(
  parameter int AW    = 8,
  parameter int DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   ram [0:(1<<AW)-1];
  logic [7:0]    fifo_mem [0:DEPTH-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic [3:0]  region;
  logic        sel_ram;
  logic        sel_led;
  logic        sel_sw;
  logic        sel_fdat;
  logic        sel_fstat;
  logic        full;
  logic        empty;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic [15:0] status;
  logic [15:0] rdata;
  logic        addr_unused;

  // ADDR[11:AW] are intentionally ignored so the RAM aliases across that range.
  assign addr_unused = ^ADDR[11:AW];

  assign region    = ADDR[15:12];
  assign sel_ram   = (region == 4'h0);
  assign sel_led   = (region == 4'h1);
  assign sel_sw    = (region == 4'h3);
  assign sel_fdat  = (region == 4'h4) && !ADDR[0];
  assign sel_fstat = (region == 4'h4) &&  ADDR[0];

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign char_valid = !empty;
  assign char_data  = fifo_mem[rd_ptr];

  assign pop      = char_valid && char_ready;
  assign push_req = W && sel_fdat;
  // A push while full succeeds only if the head leaves on the same edge.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    status            = '0;
    status[15]        = overflow;
    status[14]        = full;
    status[13]        = empty;
    status[CW-1:0]    = count;
  end

  always_comb begin
    rdata = 16'h0000;
    if (sel_ram)        rdata = ram[ADDR[AW-1:0]];
    else if (sel_led)   rdata = {6'b0, LEDR};
    else if (sel_sw)    rdata = {6'b0, SW};
    else if (sel_fstat) rdata = status;
  end

  // RAM and FIFO storage carry no reset; only their control state does.
  always_ff @(posedge Clock) begin
    if (!Reset && W && sel_ram)
      ram[ADDR[AW-1:0]] <= DOUT;
  end

  always_ff @(posedge Clock) begin
    if (!Reset && push_ok)
      fifo_mem[wr_ptr] <= DOUT[7:0];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      DIN  <= 16'h0000;
      LEDR <= 10'h000;
    end else begin
      DIN <= rdata;
      if (W && sel_led)
        LEDR <= DOUT[9:0];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (pop && !push_ok)
        count <= count - 1'b1;
      if (W && sel_fstat)
        overflow <= 1'b0;
      else if (push_req && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed vector table followed by randomized traffic against a queue-based model.
module tb_mem_io_responder;

  localparam int DEPTH = 8;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;

  always #5 Clock = ~Clock;

  mem_io_responder #(.AW(8), .DEPTH(DEPTH)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ADDR       (ADDR),
    .DOUT       (DOUT),
    .W          (W),
    .DIN        (DIN),
    .SW         (SW),
    .LEDR       (LEDR),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready)
  );

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic        rdy;
    logic [3:0]  ck;   // [0] DIN, [1] LEDR, [2] char_valid, [3] char_data
    logic [15:0] din;
    logic [9:0]  led;
    logic        cv;
    logic [7:0]  cd;
  } vec_t;

  vec_t tv[$];

  int checks = 0;
  int errors = 0;

  logic [15:0] m_ram [256];
  logic [9:0]  m_led;
  bit          m_ov;
  logic [7:0]  m_q[$];
  logic [15:0] exp_din;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic v(input logic rst, input logic [15:0] a, input logic [15:0] d, input logic w,
                   input logic rdy, input logic [3:0] ck, input logic [15:0] din,
                   input logic [9:0] led, input logic cv, input logic [7:0] cd);
    tv.push_back('{rst, a, d, w, rdy, ck, din, led, cv, cd});
  endtask

  // Reference model: one bus cycle, read value taken before this edge's updates.
  task automatic model_step(input logic rst, input logic [15:0] a, input logic [15:0] d,
                            input logic w, input logic rdy);
    int n;
    bit pop;
    bit push;
    n = m_q.size();
    if (rst) begin
      exp_din = 16'h0000;
      m_led   = 10'h000;
      m_ov    = 1'b0;
      m_q.delete();
      return;
    end
    case (a[15:12])
      4'h0:    exp_din = m_ram[a[7:0]];
      4'h1:    exp_din = {6'b0, m_led};
      4'h3:    exp_din = {6'b0, SW};
      4'h4:    exp_din = a[0] ? {m_ov, n == DEPTH, n == 0, 9'b0, 4'(n)} : 16'h0000;
      default: exp_din = 16'h0000;
    endcase
    pop  = (n > 0) && rdy;
    push = w && (a[15:12] == 4'h4) && !a[0];
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (n == DEPTH && !pop) m_ov = 1'b1;
      else m_q.push_back(d[7:0]);
    end
    if (w) begin
      case (a[15:12])
        4'h0:    m_ram[a[7:0]] = d;
        4'h1:    m_led = d[9:0];
        4'h4:    if (a[0]) m_ov = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic rst, input logic [15:0] a, input logic [15:0] d,
                       input logic w, input logic rdy);
    Reset = rst; ADDR = a; DOUT = d; W = w; char_ready = rdy;
    model_step(rst, a, d, w, rdy);
    @(posedge Clock);
    #1;
  endtask

  logic [15:0] ra;
  logic [3:0]  rg;
  logic        rw;
  logic        rr;
  logic        rrst;
  logic [7:0]  drain_head [8];

  initial begin
    Reset = 1'b1; ADDR = '0; DOUT = '0; W = 1'b0; char_ready = 1'b0; SW = 10'h155;
    drain_head = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A, 8'h00};

    v(1, 16'h0000, 16'h0000, 0, 0, 4'b0111, 16'h0000, 10'h000, 0, 8'h00);
    v(0, 16'h0005, 16'hBEEF, 1, 0, 4'b0110, 16'h0000, 10'h000, 0, 8'h00);
    v(0, 16'h0005, 16'h0000, 0, 0, 4'b0001, 16'hBEEF, 10'h000, 0, 8'h00);
    v(0, 16'h0105, 16'h0000, 0, 0, 4'b0001, 16'hBEEF, 10'h000, 0, 8'h00);
    v(0, 16'h0005, 16'h1111, 1, 0, 4'b0001, 16'hBEEF, 10'h000, 0, 8'h00);
    v(0, 16'h0005, 16'h2222, 1, 0, 4'b0001, 16'h1111, 10'h000, 0, 8'h00);
    v(0, 16'h0005, 16'h0000, 0, 0, 4'b0001, 16'h2222, 10'h000, 0, 8'h00);
    v(0, 16'h1000, 16'hFFFF, 1, 0, 4'b0011, 16'h0000, 10'h3FF, 0, 8'h00);
    v(0, 16'h1000, 16'h0000, 0, 0, 4'b0011, 16'h03FF, 10'h3FF, 0, 8'h00);
    v(0, 16'h3000, 16'h0000, 0, 0, 4'b0001, 16'h0155, 10'h000, 0, 8'h00);
    v(0, 16'h3000, 16'hFFFF, 1, 0, 4'b0011, 16'h0155, 10'h3FF, 0, 8'h00);
    v(0, 16'h7000, 16'h0000, 0, 0, 4'b0001, 16'h0000, 10'h000, 0, 8'h00);
    for (int i = 0; i < 9; i++)
      v(0, 16'h4000, 16'(8'h41 + i), 1, 0, 4'b1101, 16'h0000, 10'h000, 1, 8'h41);
    v(0, 16'h4001, 16'h0000, 0, 0, 4'b1101, 16'hC008, 10'h000, 1, 8'h41);
    for (int j = 0; j < 8; j++)
      v(0, 16'h4001, 16'h0000, 0, 1, (j < 7) ? 4'b1101 : 4'b0101,
        (j == 0) ? 16'hC008 : (16'h8000 | 16'(8 - j)), 10'h000, (j < 7), 8'(8'h42 + j));
    v(0, 16'h4001, 16'h0000, 0, 1, 4'b0101, 16'hA000, 10'h000, 0, 8'h00);
    v(0, 16'h4001, 16'h0000, 1, 0, 4'b0001, 16'hA000, 10'h000, 0, 8'h00);
    v(0, 16'h4001, 16'h0000, 0, 0, 4'b0001, 16'h2000, 10'h000, 0, 8'h00);
    for (int i = 0; i < 8; i++)
      v(0, 16'h4000, 16'(8'h61 + i), 1, 0, 4'b1101, 16'h0000, 10'h000, 1, 8'h61);
    v(0, 16'h4000, 16'h005A, 1, 1, 4'b1101, 16'h0000, 10'h000, 1, 8'h62);
    v(0, 16'h4001, 16'h0000, 0, 0, 4'b1101, 16'h4008, 10'h000, 1, 8'h62);
    for (int j = 0; j < 8; j++)
      v(0, 16'h4001, 16'h0000, 0, 1, (j < 7) ? 4'b1101 : 4'b0101,
        (j == 0) ? 16'h4008 : 16'(8 - j), 10'h000, (j < 7), drain_head[j]);
    v(0, 16'h4000, 16'h0077, 1, 1, 4'b1101, 16'h0000, 10'h000, 1, 8'h77);
    v(0, 16'h4001, 16'h0000, 0, 1, 4'b0101, 16'h0001, 10'h000, 0, 8'h00);
    for (int i = 0; i < 3; i++)
      v(0, 16'h4000, 16'(8'h31 + i), 1, 0, 4'b1101, 16'h0000, 10'h000, 1, 8'h31);
    v(0, 16'h1000, 16'h002A, 1, 0, 4'b1110, 16'h0000, 10'h02A, 1, 8'h31);
    v(1, 16'h4000, 16'h0099, 1, 1, 4'b0111, 16'h0000, 10'h000, 0, 8'h00);
    v(0, 16'h4001, 16'h0000, 0, 0, 4'b0111, 16'h2000, 10'h000, 0, 8'h00);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].addr, tv[i].dout, tv[i].w, tv[i].rdy);
      if (tv[i].ck[0]) chk($sformatf("v%0d din", i), DIN, tv[i].din);
      if (tv[i].ck[1]) chk($sformatf("v%0d ledr", i), {6'b0, LEDR}, {6'b0, tv[i].led});
      if (tv[i].ck[2]) chk($sformatf("v%0d char_valid", i), {15'b0, char_valid}, {15'b0, tv[i].cv});
      if (tv[i].ck[3]) chk($sformatf("v%0d char_data", i), {8'b0, char_data}, {8'b0, tv[i].cd});
    end

    // Random phase: reset, fill RAM through the bus, then mixed traffic.
    drive(1, 16'h0000, 16'h0000, 0, 0);
    for (int a = 0; a < 256; a++)
      drive(0, 16'(a), 16'($urandom), 1, 0);
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    rg = 4'h0;
        2:       rg = 4'h1;
        3:       rg = 4'h3;
        4, 5, 6: rg = 4'h4;
        7:       rg = 4'h2;
        8:       rg = 4'h5;
        default: rg = 4'hF;
      endcase
      ra   = {rg, 12'($urandom)};
      rw   = ($urandom_range(0, 2) != 0);
      rr   = (((i / 150) % 2) == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      rrst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) SW = 10'($urandom);
      drive(rrst, ra, 16'($urandom), rw, rr);
      chk("rand din", DIN, exp_din);
      chk("rand ledr", {6'b0, LEDR}, {6'b0, m_led});
      chk("rand char_valid", {15'b0, char_valid}, {15'b0, m_q.size() > 0});
      if (m_q.size() > 0) chk("rand char_data", {8'b0, char_data}, {8'b0, m_q[0]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
